// File: rtl/int_pkg.sv
// Shared definitions for the interrupt request arbiter: cause codes, eret
// grant encodings, FSM states and small priority helpers.
package int_pkg;

  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_1    = 2'd1;
  localparam logic [1:0] CODE_2    = 2'd2;
  localparam logic [1:0] CODE_3    = 2'd3;

  localparam logic [3:0] IG_NONE  = 4'b0000;
  localparam logic [3:0] IG_CODE1 = 4'b0001;
  localparam logic [3:0] IG_CODE2 = 4'b0010;
  localparam logic [3:0] IG_CODE3 = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Code of the highest set bit (bit 2 -> code 3), CODE_NONE when empty.
  function automatic logic [1:0] hi_code(input logic [2:0] v);
    if (v[2])      hi_code = CODE_3;
    else if (v[1]) hi_code = CODE_2;
    else if (v[0]) hi_code = CODE_1;
    else           hi_code = CODE_NONE;
  endfunction

  // One-hot line vector for a cause code; CODE_NONE maps to no line.
  function automatic logic [2:0] code_onehot(input logic [1:0] c);
    case (c)
      CODE_1:  code_onehot = 3'b001;
      CODE_2:  code_onehot = 3'b010;
      CODE_3:  code_onehot = 3'b100;
      default: code_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Combinational priority encoder: current in-service level and the best
// eligible request that would preempt it.
module int_prio_enc
  import int_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] isr,
  output logic       cand_vld,
  output logic [1:0] cand_code,
  output logic [1:0] level
);

  logic [1:0] top_code;

  // The highest request is the only one that can beat the current level,
  // so comparing it alone is enough to decide preemption.
  always_comb begin
    level     = hi_code(isr);
    top_code  = hi_code(req);
    cand_vld  = (top_code > level);
    cand_code = cand_vld ? top_code : CODE_NONE;
  end

endmodule

// File: rtl/int_req_arbiter.sv
// Source-side interrupt arbiter: edge-detects request lines, keeps them
// pending, issues one-cycle break pulses with a cause code and tracks
// nested in-service levels retired by the controller's eret grant.
module int_req_arbiter
  import int_pkg::*;
(
  input  logic       in_CLK,
  input  logic       in_RST,
  input  logic [2:0] in_irq,
  input  logic [2:0] in_mask,
  input  logic       in_IE,
  input  logic       in_stall,
  input  logic [3:0] in_IG,
  output logic       out_BK,
  output logic [1:0] out_code,
  output logic [2:0] out_pending,
  output logic [2:0] out_isr
);

  state_t     state, state_nxt;
  logic [2:0] irq_prev;
  logic [2:0] pending;
  logic [2:0] isr;
  logic [2:0] rise;
  logic [2:0] ig_clr;
  logic [2:0] isr_eff;
  logic [2:0] issue_vec;
  logic       issue;
  logic       cand_vld;
  logic [1:0] cand_code;
  logic [1:0] level;

  // Rising edges and grant decode; the level is judged on isr after this
  // cycle's grant so a retire and a new break can share one edge.
  always_comb begin
    rise   = in_irq & ~irq_prev;
    ig_clr = 3'b000;
    case (in_IG)
      IG_CODE1: ig_clr = 3'b001;
      IG_CODE2: ig_clr = 3'b010;
      IG_CODE3: ig_clr = 3'b100;
      default:  ig_clr = 3'b000;
    endcase
    isr_eff   = isr & ~ig_clr;
    issue_vec = issue ? code_onehot(cand_code) : 3'b000;
  end

  int_prio_enc u_prio (
    .req       (pending & in_mask),
    .isr       (isr_eff),
    .cand_vld  (cand_vld),
    .cand_code (cand_code),
    .level     (level)
  );

  // FSM state register.
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and break decision; BREAK and HOLD enforce pulse spacing.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cand_vld && in_IE && !in_stall) begin
          issue     = 1'b1;
          state_nxt = ST_BREAK;
        end
      end
      ST_BREAK: state_nxt = ST_HOLD;
      ST_HOLD:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Edge history, pending/in-service tracking and registered break outputs.
  // A rise on the line being serviced re-arms pending as a fresh request.
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      irq_prev <= 3'b000;
      pending  <= 3'b000;
      isr      <= 3'b000;
      out_BK   <= 1'b0;
      out_code <= CODE_NONE;
    end else begin
      irq_prev <= in_irq;
      pending  <= (pending & ~issue_vec) | rise;
      isr      <= isr_eff | issue_vec;
      out_BK   <= issue;
      out_code <= issue ? cand_code : CODE_NONE;
    end
  end

  assign out_pending = pending;
  assign out_isr     = isr;

endmodule

// File: tb/tb_int_req_arbiter.sv
// Scoreboard bench for int_req_arbiter: stimulus pushes expected break
// pulses (code and cycle); a monitor pops and compares on every pulse.
module tb_int_req_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] in_irq;
  logic [2:0] in_mask;
  logic       in_IE;
  logic       in_stall;
  logic [3:0] in_IG;
  logic       out_BK;
  logic [1:0] out_code;
  logic [2:0] out_pending;
  logic [2:0] out_isr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [1:0] code;
    int         at;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int_req_arbiter dut (
    .in_CLK      (clk),
    .in_RST      (rst),
    .in_irq      (in_irq),
    .in_mask     (in_mask),
    .in_IE       (in_IE),
    .in_stall    (in_stall),
    .in_IG       (in_IG),
    .out_BK      (out_BK),
    .out_code    (out_code),
    .out_pending (out_pending),
    .out_isr     (out_isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every break pulse must match the head of the queue exactly.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].at < cyc) begin
      checks++;
      failures++;
      $display("FAIL bk_missing code=%0d expected_at=%0d now=%0d", q[0].code, q[0].at, cyc);
      void'(q.pop_front());
    end
    if (out_BK === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL bk_unexpected cycle=%0d code=%0d required=no pulse", cyc, out_code);
      end else begin
        e = q.pop_front();
        if (out_code !== e.code || cyc != e.at) begin
          failures++;
          $display("FAIL bk_event actual code=%0d cycle=%0d required code=%0d cycle=%0d",
                   out_code, cyc, e.code, e.at);
        end
      end
    end else if (out_code !== 2'b00) begin
      checks++;
      failures++;
      $display("FAIL code_idle cycle=%0d actual=%0d required=0", cyc, out_code);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_bk(input logic [1:0] code, input int dly);
    exp_t x;
    x.code = code;
    x.at   = cyc + dly;
    q.push_back(x);
  endtask

  task automatic pulse_irq(input logic [2:0] v);
    in_irq = v;
    step(1);
    in_irq = 3'b000;
  endtask

  task automatic grant(input logic [3:0] g);
    in_IG = g;
    step(1);
    in_IG = 4'b0000;
  endtask

  initial begin
    rst      = 1'b1;
    in_irq   = 3'b000;
    in_mask  = 3'b111;
    in_IE    = 1'b1;
    in_stall = 1'b0;
    in_IG    = 4'b0000;
    step(3);
    chk("rst_bk", {7'd0, out_BK}, 8'd0);
    chk("rst_code", {6'd0, out_code}, 8'd0);
    chk("rst_pending", {5'd0, out_pending}, 8'd0);
    chk("rst_isr", {5'd0, out_isr}, 8'd0);
    rst = 1'b0;
    step(2);

    // Single request on line 1.
    expect_bk(2'd1, 2);
    pulse_irq(3'b001);
    chk("t1_pending_set", {5'd0, out_pending}, 8'h01);
    step(1);
    chk("t1_isr", {5'd0, out_isr}, 8'h01);
    chk("t1_pending_clr", {5'd0, out_pending}, 8'h00);
    step(2);
    grant(4'b0001);
    chk("t1_isr_retired", {5'd0, out_isr}, 8'h00);

    // Lines 1 and 3 together: code 3 first, code 1 after its grant.
    expect_bk(2'd3, 2);
    pulse_irq(3'b101);
    step(4);
    chk("t2_pending", {5'd0, out_pending}, 8'h01);
    chk("t2_isr", {5'd0, out_isr}, 8'h04);
    expect_bk(2'd1, 1);
    grant(4'b0100);
    chk("t2_isr_after", {5'd0, out_isr}, 8'h01);
    step(2);
    grant(4'b0001);
    chk("t2_isr_done", {5'd0, out_isr}, 8'h00);

    // Nesting: code 2 preempts code 1.
    expect_bk(2'd1, 2);
    pulse_irq(3'b001);
    step(3);
    expect_bk(2'd2, 2);
    pulse_irq(3'b010);
    step(1);
    chk("t3_isr_nested", {5'd0, out_isr}, 8'h03);
    step(2);
    grant(4'b0010);
    chk("t3_isr_unnest", {5'd0, out_isr}, 8'h01);
    grant(4'b0001);
    chk("t3_isr_done", {5'd0, out_isr}, 8'h00);

    // Lower code waits behind code 3 until it retires.
    expect_bk(2'd3, 2);
    pulse_irq(3'b100);
    step(3);
    pulse_irq(3'b001);
    step(4);
    chk("t4_pending_wait", {5'd0, out_pending}, 8'h01);
    chk("t4_isr", {5'd0, out_isr}, 8'h04);
    expect_bk(2'd1, 1);
    grant(4'b0100);
    step(2);
    grant(4'b0001);
    chk("t4_isr_done", {5'd0, out_isr}, 8'h00);

    // Stall holds the break back.
    in_stall = 1'b1;
    pulse_irq(3'b001);
    step(3);
    chk("t5_stall_pending", {5'd0, out_pending}, 8'h01);
    expect_bk(2'd1, 1);
    in_stall = 1'b0;
    step(3);
    grant(4'b0001);

    // Global enable low holds the break back.
    in_IE = 1'b0;
    pulse_irq(3'b010);
    step(3);
    chk("t5_ie_pending", {5'd0, out_pending}, 8'h02);
    expect_bk(2'd2, 1);
    in_IE = 1'b1;
    step(3);
    grant(4'b0010);
    chk("t5_ie_isr", {5'd0, out_isr}, 8'h00);

    // Masked line stays pending; unmask coincides with a new rise on it.
    in_mask = 3'b110;
    pulse_irq(3'b001);
    step(3);
    chk("t5_mask_pending", {5'd0, out_pending}, 8'h01);
    expect_bk(2'd1, 1);
    in_mask = 3'b111;
    in_irq  = 3'b001;
    step(1);
    in_irq = 3'b000;
    chk("t5_rearm_pending", {5'd0, out_pending}, 8'h01);
    chk("t5_rearm_isr", {5'd0, out_isr}, 8'h01);
    step(4);
    expect_bk(2'd1, 1);
    grant(4'b0001);
    chk("t5_regrant_isr", {5'd0, out_isr}, 8'h01);
    chk("t5_regrant_pending", {5'd0, out_pending}, 8'h00);
    step(2);
    grant(4'b0001);
    chk("t5_final_isr", {5'd0, out_isr}, 8'h00);

    // Reset asserted during the BREAK cycle.
    pulse_irq(3'b100);
    @(posedge clk);
    #1;
    chk("t6_bk_before_rst", {5'd0, out_BK, out_code}, 8'h07);
    rst = 1'b1;
    #1;
    chk("t6_bk_rst", {7'd0, out_BK}, 8'd0);
    chk("t6_pending_rst", {5'd0, out_pending}, 8'h00);
    chk("t6_isr_rst", {5'd0, out_isr}, 8'h00);
    step(2);
    rst = 1'b0;
    step(1);
    grant(4'b0001);
    chk("t6_stray_grant_isr", {5'd0, out_isr}, 8'h00);
    step(3);

    // Line held high across reset release counts as a rise.
    in_irq = 3'b010;
    rst    = 1'b1;
    step(2);
    expect_bk(2'd2, 2);
    rst = 1'b0;
    step(1);
    chk("t7_pending_release", {5'd0, out_pending}, 8'h02);
    in_irq = 3'b000;
    step(3);
    grant(4'b0010);
    chk("t7_isr_done", {5'd0, out_isr}, 8'h00);

    step(4);
    chk("queue_empty", q.size(), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
